// File: rtl/quad_decoder_pkg.sv
// Shared definitions for the quadrature decoder: phase encodings, step codes
// and the Gray-code transition classifier.
package quad_pkg;

  // Phase state encodings, {A, B}
  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S01 = 2'b01;

  // Default number of consecutive stable samples for the glitch filter
  localparam int FILT_DEFAULT = 3;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_UP      = 2'd1,
    STEP_DOWN    = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_t;

  // Next phase in the up (A leads B) direction
  function automatic logic [1:0] phase_next(input logic [1:0] ph);
    case (ph)
      S00:     return S10;
      S10:     return S11;
      S11:     return S01;
      default: return S00;
    endcase
  endfunction

  // Classify a phase transition: equal, forward neighbour, reverse neighbour,
  // or a double-bit jump that cannot be attributed to a direction.
  function automatic step_t classify(input logic [1:0] prev, input logic [1:0] cur);
    if (cur == prev)                  return STEP_NONE;
    else if (cur == phase_next(prev)) return STEP_UP;
    else if (prev == phase_next(cur)) return STEP_DOWN;
    else                              return STEP_ILLEGAL;
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder pin / control / status bundle for the quadrature decoder.
// slave = decoder side, master = board pins plus the controller reading position.
interface quad_decoder_if #(parameter int WIDTH = 16);
  logic             A;
  logic             B;
  logic             I;
  logic             en;
  logic             clr;
  logic             idx_clr_en;
  logic             err_clr;
  logic [WIDTH-1:0] pos;
  logic             dir;
  logic             step;
  logic             idx;
  logic             err;

  modport master (
    output A, B, I, en, clr, idx_clr_en, err_clr,
    input  pos, dir, step, idx, err
  );

  modport slave (
    input  A, B, I, en, clr, idx_clr_en, err_clr,
    output pos, dir, step, idx, err
  );
endinterface

// File: rtl/quad_sync_filter.sv
// One encoder input bit: 2-FF synchroniser followed by a stability filter.
// The filtered output only follows the synced bit once it has differed for
// FILT consecutive edges; shorter pulses are dropped.
module quad_sync_filter import quad_pkg::*; #(
  parameter int FILT = FILT_DEFAULT
) (
  input  logic CLK,
  input  logic Reset_n,
  input  logic d,
  output logic q,
  output logic settled
);

  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

  logic          sync1_reg;
  logic          sync2_reg;
  logic          primed1_reg;
  logic          primed2_reg;
  logic          filt_reg;
  logic [CW-1:0] cnt_reg;

  // Synchronise the asynchronous pin; primed marks when sync2 holds a real sample
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      primed1_reg <= 1'b0;
      primed2_reg <= 1'b0;
    end else begin
      sync1_reg   <= d;
      sync2_reg   <= sync1_reg;
      primed1_reg <= 1'b1;
      primed2_reg <= primed1_reg;
    end
  end

  // Count consecutive disagreeing samples; adopt the new level on the FILT-th one
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      filt_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (sync2_reg == filt_reg) begin
      cnt_reg  <= '0;
    end else if (cnt_reg == CW'(FILT - 1)) begin
      filt_reg <= sync2_reg;
      cnt_reg  <= '0;
    end else begin
      cnt_reg  <= cnt_reg + CW'(1);
    end
  end

  assign q       = filt_reg;
  // Filtered value reflects the pin and no change is pending
  assign settled = primed2_reg && (sync2_reg == filt_reg);

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder top: filters A/B/I, decodes Gray-code phase steps and
// keeps a wrapping position counter with direction, step, index and error flags.
module quad_decoder import quad_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int FILT  = FILT_DEFAULT
) (
  input  logic          CLK,
  input  logic          Reset_n,
  quad_decoder_if.slave bus
);

  logic [2:0]       raw_in;
  logic [2:0]       filt_q;
  logic [2:0]       filt_settled;
  logic [1:0]       ab;
  logic             i_filt;
  logic             idx_rise;
  logic             counting;
  step_t            code;

  logic [1:0]       ph_reg;
  logic             init_reg;
  logic             i_prev_reg;
  logic [WIDTH-1:0] pos_reg;
  logic             dir_reg;
  logic             step_reg;
  logic             idx_reg;
  logic             err_reg;

  assign raw_in = {bus.I, bus.B, bus.A};

  for (genvar gi = 0; gi < 3; gi++) begin : g_in
    quad_sync_filter #(.FILT(FILT)) u_filt (
      .CLK     (CLK),
      .Reset_n (Reset_n),
      .d       (raw_in[gi]),
      .q       (filt_q[gi]),
      .settled (filt_settled[gi])
    );
  end

  assign ab       = {filt_q[0], filt_q[1]};
  assign i_filt   = filt_q[2];
  assign idx_rise = i_filt & ~i_prev_reg;
  assign counting = bus.en & ~init_reg;
  assign code     = classify(ph_reg, ab);

  // Phase state always follows filtered AB (also resyncs after an illegal jump);
  // init holds off decoding until the input path has settled after reset or enable
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      ph_reg   <= S00;
      init_reg <= 1'b1;
    end else begin
      ph_reg <= ab;
      if (!bus.en)
        init_reg <= 1'b1;
      else if (init_reg && (&filt_settled))
        init_reg <= 1'b0;
    end
  end

  // Index edge detect; idx pulses on every filtered rising edge of I
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      i_prev_reg <= 1'b0;
      idx_reg    <= 1'b0;
    end else begin
      i_prev_reg <= i_filt;
      idx_reg    <= idx_rise;
    end
  end

  // Position counter: clr beats index clear beats step; a step still updates dir/step when cleared
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      pos_reg  <= '0;
      dir_reg  <= 1'b0;
      step_reg <= 1'b0;
    end else begin
      step_reg <= 1'b0;
      if (bus.clr)
        pos_reg <= '0;
      else if (bus.en && idx_rise && bus.idx_clr_en)
        pos_reg <= '0;
      else if (counting && code == STEP_UP)
        pos_reg <= pos_reg + WIDTH'(1);
      else if (counting && code == STEP_DOWN)
        pos_reg <= pos_reg - WIDTH'(1);

      if (counting && (code == STEP_UP || code == STEP_DOWN)) begin
        dir_reg  <= (code == STEP_UP);
        step_reg <= 1'b1;
      end
    end
  end

  // Sticky error; a fresh illegal transition outranks err_clr
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n)
      err_reg <= 1'b0;
    else if (counting && code == STEP_ILLEGAL)
      err_reg <= 1'b1;
    else if (bus.err_clr)
      err_reg <= 1'b0;
  end

  assign bus.pos  = pos_reg;
  assign bus.dir  = dir_reg;
  assign bus.step = step_reg;
  assign bus.idx  = idx_reg;
  assign bus.err  = err_reg;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: expected steps and index pulses are queued
// when the pins are driven and checked (value and latency) when the DUT pulses.
module tb_quad_decoder;

  localparam int WIDTH = 16;
  localparam int FILT  = 3;
  localparam int LAT   = FILT + 3;

  typedef struct {
    logic [WIDTH-1:0] pos;
    logic             dir;
    int               cyc;
  } step_exp_t;

  logic CLK = 1'b0;
  logic Reset_n = 1'b0;

  always #5 CLK = ~CLK;

  quad_decoder_if #(.WIDTH(WIDTH)) bus ();

  quad_decoder #(.WIDTH(WIDTH), .FILT(FILT)) dut (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  step_exp_t        step_q[$];
  int               idx_q[$];
  int               total = 0;
  int               bad = 0;
  int               cyc = 0;
  int               steps_seen = 0;
  step_exp_t        e;
  int               ic;

  logic [1:0]       ph_m;
  logic [WIDTH-1:0] exp_pos;
  logic             exp_dir;
  int               base;

  logic [1:0] up_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  // Drive a new AB phase and predict its effect; counting=0 means en is low
  task automatic drive_ab(input logic [1:0] ab, input bit cnt_en);
    if (cnt_en) begin
      if (ab == fwd(ph_m)) begin
        exp_pos = exp_pos + 1'b1;
        exp_dir = 1'b1;
        step_q.push_back('{pos: exp_pos, dir: exp_dir, cyc: cyc});
      end else if (ph_m == fwd(ab)) begin
        exp_pos = exp_pos - 1'b1;
        exp_dir = 1'b0;
        step_q.push_back('{pos: exp_pos, dir: exp_dir, cyc: cyc});
      end
    end
    ph_m  = ab;
    bus.A = ab[1];
    bus.B = ab[0];
    tick(8);
  endtask

  // Step monitor: every pulse must match the oldest queued expectation
  always @(posedge CLK) begin
    #1;
    if (Reset_n && bus.step === 1'b1) begin
      steps_seen++;
      check("step_expected", 32'(step_q.size() > 0), 32'd1);
      if (step_q.size() > 0) begin
        e = step_q.pop_front();
        check("step_pos", 32'(bus.pos), 32'(e.pos));
        check("step_dir", 32'(bus.dir), 32'(e.dir));
        check("step_latency", 32'(cyc - e.cyc), 32'(LAT));
      end
    end
  end

  // Index monitor
  always @(posedge CLK) begin
    #1;
    if (Reset_n && bus.idx === 1'b1) begin
      check("idx_expected", 32'(idx_q.size() > 0), 32'd1);
      if (idx_q.size() > 0) begin
        ic = idx_q.pop_front();
        check("idx_latency", 32'(cyc - ic), 32'(LAT));
      end
    end
  end

  initial begin
    bus.A = 1'b1; bus.B = 1'b1; bus.I = 1'b0;
    bus.en = 1'b1; bus.clr = 1'b0; bus.idx_clr_en = 1'b0; bus.err_clr = 1'b0;
    ph_m = 2'b11; exp_pos = '0; exp_dir = 1'b0;

    // Reset with A=B=1, then settle: init absorbs the 11 phase
    tick(3);
    check("rst_pos", 32'(bus.pos), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_dir", 32'(bus.dir), 32'd0);
    check("rst_step", 32'(bus.step), 32'd0);
    Reset_n = 1'b1;
    tick(20);
    check("init_pos", 32'(bus.pos), 32'd0);
    check("init_err", 32'(bus.err), 32'd0);
    check("init_steps", 32'(steps_seen), 32'd0);

    // Re-reset with A=B=0 as the starting phase
    Reset_n = 1'b0;
    bus.A = 1'b0; bus.B = 1'b0; ph_m = 2'b00;
    tick(2);
    Reset_n = 1'b1;
    tick(10);

    // Four full up cycles
    base = steps_seen;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        drive_ab(up_seq[k], 1'b1);
    check("up_pos", 32'(bus.pos), 32'd16);
    check("up_dir", 32'(bus.dir), 32'd1);
    check("up_steps", 32'(steps_seen - base), 32'd16);

    // Clear, then wrap down and back
    bus.clr = 1'b1; tick(1); bus.clr = 1'b0; exp_pos = '0;
    tick(2);
    check("clr_pos", 32'(bus.pos), 32'd0);
    drive_ab(2'b01, 1'b1);
    check("wrap_dn_pos", 32'(bus.pos), 32'hFFFF);
    check("wrap_dn_dir", 32'(bus.dir), 32'd0);
    drive_ab(2'b00, 1'b1);
    check("wrap_up_pos", 32'(bus.pos), 32'd0);

    // Short glitch on A is filtered out
    bus.A = 1'b1; tick(2); bus.A = 1'b0;
    tick(10);
    check("glitch_pos", 32'(bus.pos), 32'(exp_pos));
    check("glitch_err", 32'(bus.err), 32'd0);

    // Illegal double-bit jump, then clear the error
    drive_ab(2'b11, 1'b1);
    check("illegal_err", 32'(bus.err), 32'd1);
    check("illegal_pos", 32'(bus.pos), 32'(exp_pos));
    bus.err_clr = 1'b1; tick(1); bus.err_clr = 1'b0;
    tick(1);
    check("errclr_err", 32'(bus.err), 32'd0);

    // Count to 37, then index clear
    for (int n = 0; n < 37; n++) drive_ab(fwd(ph_m), 1'b1);
    check("pos37", 32'(bus.pos), 32'd37);
    bus.idx_clr_en = 1'b1; bus.I = 1'b1; idx_q.push_back(cyc); exp_pos = '0;
    tick(8);
    check("idxclr_pos", 32'(bus.pos), 32'd0);
    bus.I = 1'b0; tick(8); bus.idx_clr_en = 1'b0;

    // Index without clear enable leaves pos alone
    drive_ab(fwd(ph_m), 1'b1);
    drive_ab(fwd(ph_m), 1'b1);
    bus.I = 1'b1; idx_q.push_back(cyc);
    tick(8);
    check("idxnoclr_pos", 32'(bus.pos), 32'd2);
    bus.I = 1'b0; tick(8);

    // clr in the same cycle as a step: pos 0 but step/dir still reported
    ph_m = fwd(ph_m);
    exp_pos = '0; exp_dir = 1'b1;
    step_q.push_back('{pos: exp_pos, dir: exp_dir, cyc: cyc});
    bus.A = ph_m[1]; bus.B = ph_m[0];
    tick(LAT - 1);
    bus.clr = 1'b1; tick(1); bus.clr = 1'b0;
    tick(4);
    check("clrstep_pos", 32'(bus.pos), 32'd0);
    check("clrstep_dir", 32'(bus.dir), 32'd1);

    // Disabled: edges tracked but not counted
    bus.en = 1'b0; tick(4);
    for (int n = 0; n < 3; n++) drive_ab(fwd(ph_m), 1'b0);
    check("dis_pos", 32'(bus.pos), 32'(exp_pos));
    check("dis_err", 32'(bus.err), 32'd0);
    bus.en = 1'b1; tick(4);
    drive_ab(fwd(ph_m), 1'b1);
    check("reen_pos", 32'(bus.pos), 32'd1);
    check("reen_err", 32'(bus.err), 32'd0);

    // Asynchronous reset mid-operation
    Reset_n = 1'b0; #1;
    check("async_rst_pos", 32'(bus.pos), 32'd0);
    tick(2);
    Reset_n = 1'b1;
    tick(12);
    check("post_rst_err", 32'(bus.err), 32'd0);

    check("step_q_empty", 32'(step_q.size()), 32'd0);
    check("idx_q_empty", 32'(idx_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
